// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution engines: default widths, FSM
// states and the output ReLU/saturation helper.
package cnn_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_W_W    = 8;
  localparam int unsigned DEF_K      = 3;
  localparam int unsigned SAT_W      = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

  // Optional ReLU followed by signed saturation into an out_w-bit range.
  function automatic logic signed [SAT_W-1:0] relu_sat(
    input logic signed [SAT_W-1:0] val,
    input int unsigned             out_w,
    input logic                    relu
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] v;
    hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 32'd1));
    v  = (relu && (val < 64'sd0)) ? 64'sd0 : val;
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_tree.sv
// KxK multiply stage followed by an adder tree with bias; both stages
// advance only on en.
module conv_mac_tree
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned W_W    = DEF_W_W,
  parameter int unsigned K      = DEF_K,
  parameter int unsigned ACC_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [K*K*DATA_W-1:0]    pixels,
  input  logic [K*K*W_W-1:0]       weights,
  input  logic signed [ACC_W-1:0]  bias,
  output logic                     sum_valid,
  output logic signed [ACC_W-1:0]  sum
);

  localparam int unsigned N      = K * K;
  localparam int unsigned PROD_W = DATA_W + W_W + 1;

  logic signed [PROD_W-1:0] prod_c [N];
  logic signed [PROD_W-1:0] prod_q [N];
  logic                     prod_valid;
  logic signed [ACC_W-1:0]  tree_c;

  // Pixels are unsigned, so they get a zero sign bit before the signed multiply.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      prod_c[i] = PROD_W'($signed({1'b0, pixels[i*DATA_W +: DATA_W]}))
                * PROD_W'($signed(weights[i*W_W +: W_W]));
    end
  end

  always_comb begin
    tree_c = bias;
    for (int unsigned i = 0; i < N; i++) begin
      tree_c = tree_c + ACC_W'(prod_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q     <= '{default: '0};
      prod_valid <= 1'b0;
      sum_valid  <= 1'b0;
      sum        <= '0;
    end else if (en) begin
      prod_q     <= prod_c;
      prod_valid <= in_valid;
      sum_valid  <= prod_valid;
      sum        <= tree_c;
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Streaming KxK convolution for one output row: line-buffer reads, sliding
// window with a one-column skid, MAC pipeline and backpressured output.
module conv_window_mac
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned W_W    = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned LINE_W = 100,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(K)-1:0]        row_sel,
  input  logic [K*K*W_W-1:0]          weights,
  input  logic signed [ACC_W-1:0]     bias,
  input  logic                        relu_en,
  output logic                        lb_rd_en,
  output logic [ADDR_W-1:0]           lb_rd_addr,
  input  logic [K*DATA_W-1:0]         lb_rd_data,
  output logic signed [OUT_W-1:0]     out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned SEL_W  = $clog2(K);
  localparam int unsigned FILL_W = $clog2(K);
  localparam int unsigned CNT_W  = $clog2(LINE_W + 1);

  conv_state_e              state;
  logic [SEL_W-1:0]         row_sel_q;
  logic [K*K*W_W-1:0]       weights_q;
  logic signed [ACC_W-1:0]  bias_q;
  logic                     relu_q;
  logic                     rd_pend;
  logic                     skid_full;
  logic [DATA_W-1:0]        skid_col [K];
  logic [DATA_W-1:0]        win      [K][K];
  logic [DATA_W-1:0]        nwin     [K][K];
  logic [DATA_W-1:0]        ret_col  [K];
  logic [DATA_W-1:0]        new_col  [K];
  logic [FILL_W-1:0]        fill_cnt;
  logic [CNT_W-1:0]         out_cnt;
  logic                     en;
  logic                     shift;
  logic                     job_valid;
  logic [K*K*DATA_W-1:0]    job_pixels;
  logic                     sum_valid;
  logic signed [ACC_W-1:0]  sum;
  logic signed [SAT_W-1:0]  res_c;

  assign en       = !out_valid || out_ready;
  assign lb_rd_en = (state == ST_RUN) && en && !skid_full;

  // Undo the line-buffer rotation so row 0 is always the oldest image row.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned r = 0; r < K; r++) begin
      ret_col[r] = '0;
      idx = (32'(row_sel_q) + r) % K;
      for (int unsigned j = 0; j < K; j++) begin
        if (idx == j) begin
          ret_col[r] = lb_rd_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  // A parked column always goes first; a read never issues while it is parked.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      new_col[r] = skid_full ? skid_col[r] : ret_col[r];
      for (int unsigned c = 0; c < K - 1; c++) begin
        nwin[r][c] = win[r][c+1];
      end
      nwin[r][K-1] = new_col[r];
    end
  end

  assign shift     = en && (skid_full || rd_pend);
  assign job_valid = shift && (fill_cnt == FILL_W'(K - 1));

  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        job_pixels[(r*K+c)*DATA_W +: DATA_W] = nwin[r][c];
      end
    end
  end

  conv_mac_tree #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .K      (K),
    .ACC_W  (ACC_W)
  ) u_mac_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (job_valid),
    .pixels    (job_pixels),
    .weights   (weights_q),
    .bias      (bias_q),
    .sum_valid (sum_valid),
    .sum       (sum)
  );

  assign res_c = relu_sat(SAT_W'(sum), OUT_W, relu_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lb_rd_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      row_sel_q  <= '0;
      weights_q  <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      rd_pend    <= 1'b0;
      skid_full  <= 1'b0;
      skid_col   <= '{default: '0};
      win        <= '{default: '0};
      fill_cnt   <= '0;
      out_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= lb_rd_en;

      if (shift) begin
        skid_full <= 1'b0;
        win       <= nwin;
        if (fill_cnt != FILL_W'(K - 1)) begin
          fill_cnt <= fill_cnt + FILL_W'(1);
        end
      end
      if (rd_pend && !en) begin
        skid_full <= 1'b1;
        skid_col  <= ret_col;
      end

      // Output stage: a new result may load in the same cycle the old one leaves.
      if (en) begin
        out_valid <= sum_valid;
        if (sum_valid) begin
          out_data <= OUT_W'(res_c);
        end
      end
      if (out_valid && out_ready) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            row_sel_q  <= row_sel;
            weights_q  <= weights;
            bias_q     <= bias;
            relu_q     <= relu_en;
            lb_rd_addr <= '0;
            fill_cnt   <= '0;
            out_cnt    <= '0;
            skid_full  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (lb_rd_en) begin
            if (lb_rd_addr == ADDR_W'(LINE_W - 1)) begin
              state <= ST_DRAIN;
            end else begin
              lb_rd_addr <= lb_rd_addr + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (out_valid && out_ready && (out_cnt == CNT_W'(LINE_W - K))) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
